// File: rtl/maxpool2_stage.sv
// 2x2 stride-2 signed max pooling over a CH x IN_DIM x IN_DIM int8 map held in shared RAM.
// Each window is fetched with four reads, reduced to a running max, and written back as one output element.
module maxpool2_stage #(
  parameter int          IN_DIM   = 22,
  parameter int          CH       = 12,
  parameter logic [15:0] IN_BASE  = 16'h8000,
  parameter logic [15:0] OUT_BASE = 16'h0000,
  parameter int          RD_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_pool,
  output logic              end_pool,
  output logic [15:0]       ram_addr_r,
  input  logic signed [7:0] ram_data_r,
  output logic              ram_en_r,
  output logic [15:0]       ram_addr_w,
  output logic [7:0]        ram_data_w,
  output logic              ram_en,
  output logic              ram_wea
);

  localparam int OD = IN_DIM / 2;
  localparam int OW = (OD > 1) ? $clog2(OD) : 1;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int DW = $clog2(RD_LAT) + 1;
  // Read data returns RD_LAT edges after the address register loads; RD_LAT must be at least 2.
  localparam int PW = RD_LAT - 1;
  localparam logic [OW-1:0] OD_LAST    = OW'(OD - 1);
  localparam logic [CW-1:0] CH_LAST    = CW'(CH - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_r;
  logic [OW-1:0]     ox_r;
  logic [OW-1:0]     oy_r;
  logic [CW-1:0]     c_r;
  logic [1:0]        f_r;
  logic [DW-1:0]     d_r;
  logic              rd_first_r;
  logic [PW-1:0]     vld_pipe_r;
  logic [PW-1:0]     first_pipe_r;
  logic signed [7:0] max_r;

  logic [15:0] x_s;
  logic [15:0] y_s;
  logic [15:0] rd_addr_s;
  logic [15:0] wr_addr_s;
  logic        last_s;
  logic        smp_vld_s;
  logic        smp_first_s;

  // Window read address, output write address and end-of-map detection from the loop counters.
  always_comb begin
    x_s       = 16'h0000;
    y_s       = 16'h0000;
    rd_addr_s = 16'h0000;
    wr_addr_s = 16'h0000;
    last_s    = 1'b0;
    x_s       = 16'({ox_r, 1'b0}) + 16'(f_r[0]);
    y_s       = 16'({oy_r, 1'b0}) + 16'(f_r[1]);
    rd_addr_s = IN_BASE + x_s + (y_s * 16'(IN_DIM)) + (16'(c_r) * 16'(IN_DIM * IN_DIM));
    wr_addr_s = OUT_BASE + 16'(ox_r) + (16'(oy_r) * 16'(OD)) + (16'(c_r) * 16'(OD * OD));
    if ((ox_r == OD_LAST) && (oy_r == OD_LAST) && (c_r == CH_LAST)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Pick the tap where returning read data lines up with its request.
  always_comb begin
    smp_vld_s   = vld_pipe_r[PW-1];
    smp_first_s = first_pipe_r[PW-1];
  end

  // Control FSM: fetch four taps, wait out the read latency, write, advance ox/oy/c.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      ox_r    <= '0;
      oy_r    <= '0;
      c_r     <= '0;
      f_r     <= 2'd0;
      d_r     <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_pool) begin
            state_r <= S_FETCH;
            ox_r    <= '0;
            oy_r    <= '0;
            c_r     <= '0;
            f_r     <= 2'd0;
          end
        end
        S_FETCH: begin
          if (f_r == 2'd3) begin
            state_r <= S_DRAIN;
            f_r     <= 2'd0;
            d_r     <= '0;
          end else begin
            f_r <= f_r + 2'd1;
          end
        end
        S_DRAIN: begin
          if (d_r == DRAIN_LAST) begin
            state_r <= S_WRITE;
          end else begin
            d_r <= d_r + 1'b1;
          end
        end
        S_WRITE: begin
          if (last_s) begin
            state_r <= S_DONE;
            ox_r    <= '0;
            oy_r    <= '0;
            c_r     <= '0;
          end else begin
            state_r <= S_FETCH;
            if (ox_r == OD_LAST) begin
              ox_r <= '0;
              if (oy_r == OD_LAST) begin
                oy_r <= '0;
                c_r  <= c_r + 1'b1;
              end else begin
                oy_r <= oy_r + 1'b1;
              end
            end else begin
              ox_r <= ox_r + 1'b1;
            end
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Registered RAM ports and done pulse, decoded from the state of the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en_r   <= 1'b0;
      ram_addr_r <= 16'h0000;
      rd_first_r <= 1'b0;
      ram_en     <= 1'b0;
      ram_wea    <= 1'b0;
      ram_addr_w <= 16'h0000;
      ram_data_w <= 8'h00;
      end_pool   <= 1'b0;
    end else begin
      ram_en_r <= (state_r == S_FETCH);
      ram_en   <= (state_r == S_WRITE);
      ram_wea  <= (state_r == S_WRITE);
      end_pool <= (state_r == S_DONE);
      if (state_r == S_FETCH) begin
        ram_addr_r <= rd_addr_s;
        rd_first_r <= (f_r == 2'd0);
      end
      if (state_r == S_WRITE) begin
        ram_addr_w <= wr_addr_s;
        ram_data_w <= max_r;
      end
    end
  end

  // Delay line tagging which edges carry read data and which sample opens a new window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_r   <= '0;
      first_pipe_r <= '0;
    end else begin
      vld_pipe_r[0]   <= ram_en_r;
      first_pipe_r[0] <= rd_first_r;
      for (int i = 1; i < PW; i++) begin
        vld_pipe_r[i]   <= vld_pipe_r[i-1];
        first_pipe_r[i] <= first_pipe_r[i-1];
      end
    end
  end

  // Running signed max; ties keep the earlier sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_r <= 8'sh00;
    end else if (smp_vld_s && (smp_first_s || (ram_data_r > max_r))) begin
      max_r <= ram_data_r;
    end
  end

endmodule

// File: tb/tb_maxpool2_stage.sv
// Randomized bench for maxpool2_stage: a RAM model feeds the DUT, and a monitor checks every read and
// write against window maxima computed directly from the stored map.
module tb_maxpool2_stage;

  localparam int ID     = 22;
  localparam int OD     = 11;
  localparam int NCH    = 12;
  localparam int NOUT   = NCH * OD * OD;
  localparam int T_PASS = NOUT * 7 + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_pool;
  logic              end_pool;
  logic [15:0]       ram_addr_r;
  logic signed [7:0] ram_data_r;
  logic              ram_en_r;
  logic [15:0]       ram_addr_w;
  logic [7:0]        ram_data_w;
  logic              ram_en;
  logic              ram_wea;

  logic [7:0] mem [0:65535];
  int n_cmp = 0;
  int n_err = 0;
  int pass_id = 0;

  maxpool2_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_pool (start_pool),
    .end_pool   (end_pool),
    .ram_addr_r (ram_addr_r),
    .ram_data_r (ram_data_r),
    .ram_en_r   (ram_en_r),
    .ram_addr_w (ram_addr_w),
    .ram_data_w (ram_data_w),
    .ram_en     (ram_en),
    .ram_wea    (ram_wea)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: one register stage here plus the DUT address register gives two clocks of read latency.
  always @(posedge clk) ram_data_r <= mem[ram_addr_r];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int in_addr(int x, int y, int c);
    return 32'h8000 + x + y * ID + c * ID * ID;
  endfunction

  // i-th read of a pass: window n = i/4, tap f = i%4 (x offset f%2, y offset f/2).
  function automatic logic [15:0] exp_rd_addr(int i);
    int n, f, ox, oy, c;
    n = i / 4; f = i % 4;
    ox = n % OD; oy = (n / OD) % OD; c = n / (OD * OD);
    return 16'(in_addr(2 * ox + f % 2, 2 * oy + f / 2, c));
  endfunction

  function automatic logic [15:0] exp_wr_addr(int n);
    int ox, oy, c;
    ox = n % OD; oy = (n / OD) % OD; c = n / (OD * OD);
    return 16'(ox + oy * OD + c * OD * OD);
  endfunction

  function automatic logic [7:0] exp_wr_data(int n);
    int ox, oy, c, best, v;
    logic signed [7:0] s;
    ox = n % OD; oy = (n / OD) % OD; c = n / (OD * OD);
    best = -1000;
    for (int dy = 0; dy < 2; dy++) begin
      for (int dx = 0; dx < 2; dx++) begin
        s = mem[in_addr(2 * ox + dx, 2 * oy + dy, c)];
        v = s;
        if (v > best) best = v;
      end
    end
    return 8'(best);
  endfunction

  task automatic fill_map();
    for (int i = 0; i < NCH * ID * ID; i++) begin
      if ($urandom_range(0, 3) == 0) mem[32'h8000 + i] = 8'(8'h80 + $urandom_range(0, 2));
      else mem[32'h8000 + i] = 8'($urandom);
    end
    mem[in_addr(0, 0, 0)]   = 8'd5;
    mem[in_addr(1, 0, 0)]   = 8'hFD;
    mem[in_addr(0, 1, 0)]   = 8'd17;
    mem[in_addr(1, 1, 0)]   = 8'd9;
    mem[in_addr(20, 20, 11)] = 8'h80;
    mem[in_addr(21, 20, 11)] = 8'hFF;
    mem[in_addr(20, 21, 11)] = 8'hFF;
    mem[in_addr(21, 21, 11)] = 8'h80;
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++)
        mem[in_addr(6 + dx, 8 + dy, 5)] = 8'h80;
  endtask

  // Monitor: owns all per-pass bookkeeping; a new pass_id value marks a start request.
  initial begin
    int seen_pass, cyc, wr_idx, rd_idx;
    bit active, prev_wea, prev_end;
    seen_pass = 0; cyc = 0; wr_idx = 0; rd_idx = 0;
    active = 1'b0; prev_wea = 1'b0; prev_end = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0; prev_wea = 1'b0; prev_end = 1'b0;
        check("reset_outputs",
              {ram_en_r, ram_en, ram_wea, end_pool, ram_addr_r, ram_addr_w, ram_data_w}, 64'd0);
      end else begin
        if (pass_id != seen_pass) begin
          seen_pass = pass_id; active = 1'b1;
          cyc = 0; wr_idx = 0; rd_idx = 0;
        end else begin
          cyc++;
        end
        if (!active) begin
          check("idle_quiet", {ram_en_r, ram_en, ram_wea, end_pool}, 64'd0);
        end else begin
          check("rw_overlap", ram_en_r & ram_en, 64'd0);
          if (ram_en_r) begin
            check("rd_addr", ram_addr_r, exp_rd_addr(rd_idx));
            case (rd_idx)
              4: check("rd_addr_w1_t0", ram_addr_r, 64'h8002);
              5: check("rd_addr_w1_t1", ram_addr_r, 64'h8003);
              6: check("rd_addr_w1_t2", ram_addr_r, 64'h8018);
              7: check("rd_addr_w1_t3", ram_addr_r, 64'h8019);
              484: check("rd_addr_ch1_first", ram_addr_r, 64'h81E4);
              default: ;
            endcase
            rd_idx++;
          end
          if (ram_en || ram_wea) begin
            check("en_wea_pair", {ram_en, ram_wea}, 64'd3);
            check("wea_one_cycle", prev_wea, 64'd0);
            check("wr_addr", ram_addr_w, exp_wr_addr(wr_idx));
            check("wr_data", ram_data_w, exp_wr_data(wr_idx));
            if (wr_idx == 0) begin
              check("first_wr_latency", cyc, 64'd8);
              check("first_wr_addr", ram_addr_w, 64'h0000);
              check("first_wr_data", ram_data_w, 64'd17);
            end
            if (wr_idx == 652) check("all_min_window", ram_data_w, 64'h80);
            if (wr_idx == 1450) check("signed_tie_addr", ram_addr_w, 64'h05AA);
            if (wr_idx == NOUT - 1) begin
              check("last_wr_addr", ram_addr_w, 64'h05AB);
              check("signed_tie_data", ram_data_w, 64'hFF);
            end
            wr_idx++;
          end
          if (end_pool) begin
            check("end_single", prev_end, 64'd0);
            check("end_cycle", cyc, 64'(T_PASS));
            check("n_writes", wr_idx, 64'(NOUT));
            check("n_reads", rd_idx, 64'(NOUT * 4));
            active = 1'b0;
          end else if (cyc > T_PASS + 20) begin
            check("pass_timeout", cyc, 64'(T_PASS));
            active = 1'b0;
          end
        end
        prev_wea = ram_wea;
        prev_end = end_pool;
      end
    end
  end

  task automatic launch();
    @(posedge clk); #1;
    start_pool = 1'b1;
    pass_id++;
    @(posedge clk); #1;
    start_pool = 1'b0;
  endtask

  task automatic run_pass();
    bit seen;
    seen = 1'b0;
    launch();
    for (int i = 0; i < T_PASS + 200 && !seen; i++) begin
      @(negedge clk);
      if (end_pool) seen = 1'b1;
    end
    repeat (20) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start_pool = 1'b0;
    fill_map();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);

    run_pass();

    // The 4th window c=11, oy=10, ox=10 from the tie pins lies at index 1451; index 1450 is its left neighbour.
    fill_map();
    launch();
    repeat (2998) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);

    fill_map();
    run_pass();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
